// File: rtl/matmul_sequencer.sv
// Sequences PE array, 3x3 and 2x2 engines, then the display unit.
// Optional watchdog enabled by defining MATMUL_SEQ_TIMEOUT_EN.
module matmul_sequencer #(
  parameter logic [2:0] DISP_DONE_CODE = 3'd4,
  parameter int         CYC_W          = 16,
  parameter int         TIMEOUT_MAX    = 200,
  parameter int         TO_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             pe_done_i,
  input  logic             mm3_done_i,
  input  logic             mm2_done_i,
  input  logic [2:0]       state_display_i,
  output logic             run_pe_o,
  output logic             run_3x3_o,
  output logic             run_2x2_o,
  output logic             run_display_o,
  output logic [2:0]       state_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CYC_W-1:0] cycles_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PE   = 3'd1,
    S_M3   = 3'd2,
    S_M2   = 3'd3,
    S_DISP = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t          state;
  state_t          nxt;
  logic            running;
  logic            timeout;
  logic [TO_W-1:0] to_last;

  assign running = (state == S_PE) || (state == S_M3) ||
                   (state == S_M2) || (state == S_DISP);
  assign to_last = TO_W'(TIMEOUT_MAX - 1);

`ifdef MATMUL_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] wd;

  // Fires on the edge that would bring the count to TIMEOUT_MAX
  assign timeout = running && (wd == to_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd <= '0;
    end else if (nxt != state) begin
      wd <= '0;
    end else if (running) begin
      wd <= wd + TO_W'(1);
    end
  end
`else
  logic unused_to;

  assign unused_to = ^to_last;
  assign timeout   = 1'b0;
`endif

  // Exit conditions are tested before timeout so a same-cycle exit wins
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (start_i) nxt = S_PE;
      S_PE: begin
        if (pe_done_i)    nxt = S_M3;
        else if (timeout) nxt = S_ERR;
      end
      S_M3: begin
        if (mm3_done_i)   nxt = S_M2;
        else if (timeout) nxt = S_ERR;
      end
      S_M2: begin
        if (mm2_done_i)   nxt = S_DISP;
        else if (timeout) nxt = S_ERR;
      end
      S_DISP: begin
        if (state_display_i == DISP_DONE_CODE) nxt = S_DONE;
        else if (timeout)                      nxt = S_ERR;
      end
      S_DONE: nxt = S_IDLE;
      S_ERR:  if (start_i) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      state_o       <= 3'd0;
      run_pe_o      <= 1'b0;
      run_3x3_o     <= 1'b0;
      run_2x2_o     <= 1'b0;
      run_display_o <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      cycles_o      <= '0;
    end else begin
      state         <= nxt;
      state_o       <= nxt;
      run_pe_o      <= (nxt == S_PE);
      run_3x3_o     <= (nxt == S_M3);
      run_2x2_o     <= (nxt == S_M2);
      run_display_o <= (nxt == S_DISP);
      busy_o        <= (nxt == S_PE) || (nxt == S_M3) ||
                       (nxt == S_M2) || (nxt == S_DISP);
      done_o        <= (nxt == S_DONE);
      err_o         <= (nxt == S_ERR);
      if (state == S_IDLE && nxt == S_PE) begin
        cycles_o <= '0;
      end else if (running && cycles_o != '1) begin
        cycles_o <= cycles_o + CYC_W'(1);
      end
    end
  end

endmodule
